// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: default geometry, the
// ADD/SUB opcode encoding and helpers giving the bit bounds of a chunk.
package adder_pkg;

    localparam int unsigned ADD_WIDTH  = 32;
    localparam int unsigned ADD_STAGES = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Lowest bit index of chunk idx for a chunk width of cw.
    function automatic int unsigned chunk_lo(input int unsigned idx, input int unsigned cw);
        return idx * cw;
    endfunction

    // Highest bit index of chunk idx for a chunk width of cw.
    function automatic int unsigned chunk_hi(input int unsigned idx, input int unsigned cw);
        return (idx * cw) + cw - 1;
    endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One CW-bit slice of the pipelined adder: a purely combinational ripple
// chain of 1-bit full-adder cells.
module adder_chunk_stage #(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    logic [CW:0] c;

    // Ripple the carry through CW full-adder cells.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < CW; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[CW];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry-chained
// chunks, one chunk per stage, with valid/ready handshake on both sides.
// Optional flag outputs (zero/neg/ovf) are built when the macro
// PIPELINED_ADDER_FLAGS_EN is defined.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = ADD_WIDTH,
    parameter int unsigned STAGES = ADD_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam int unsigned CW = WIDTH / STAGES;

    op_e              op;
    logic             adv;

    // Pipeline registers, one entry per stage.
    logic             v    [STAGES];
    logic             cy   [STAGES];
    logic [WIDTH-1:0] res  [STAGES];
    logic [WIDTH-1:0] a_d  [STAGES];
    logic [WIDTH-1:0] b_d  [STAGES];

    // Combinational inputs seen by each stage and its chunk result.
    logic             st_v   [STAGES];
    logic             st_c   [STAGES];
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_res [STAGES];
    logic [CW-1:0]    ch_sum [STAGES];
    logic             ch_co  [STAGES];
    logic [WIDTH-1:0] nxt_res[STAGES];

    assign op       = op_e'(sub);
    assign adv      = ~(v[STAGES-1] & ~out_ready);
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = chunk_lo(k, CW);
        localparam int unsigned HI = chunk_hi(k, CW);

        logic [WIDTH-1:0] merged;

        if (k == 0) begin : g_first
            assign st_v[k]   = in_valid;
            assign st_a[k]   = a;
            assign st_b[k]   = (op == OP_SUB) ? ~b : b;
            assign st_c[k]   = (op == OP_SUB) ? 1'b1 : cin;
            assign st_res[k] = '0;
        end else begin : g_rest
            assign st_v[k]   = v[k-1];
            assign st_a[k]   = a_d[k-1];
            assign st_b[k]   = b_d[k-1];
            assign st_c[k]   = cy[k-1];
            assign st_res[k] = res[k-1];
        end

        adder_chunk_stage #(
            .CW (CW)
        ) u_chunk (
            .a  (st_a[k][HI:LO]),
            .b  (st_b[k][HI:LO]),
            .ci (st_c[k]),
            .s  (ch_sum[k]),
            .co (ch_co[k])
        );

        // Splice this stage's chunk into the partially built result.
        always_comb begin
            merged        = st_res[k];
            merged[HI:LO] = ch_sum[k];
        end

        assign nxt_res[k] = merged;
    end

    // Advance every stage together; hold all state while the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v[k]   <= 1'b0;
                cy[k]  <= 1'b0;
                res[k] <= '0;
                a_d[k] <= '0;
                b_d[k] <= '0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v[k]   <= st_v[k];
                cy[k]  <= ch_co[k];
                res[k] <= nxt_res[k];
                a_d[k] <= st_a[k];
                b_d[k] <= st_b[k];
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign sum       = res[STAGES-1];
    assign cout      = cy[STAGES-1];

`ifdef PIPELINED_ADDER_FLAGS_EN
    logic msb_cin;

    // Carry into the MSB, recovered from the MSB operand bits and sum bit.
    assign msb_cin = st_a[STAGES-1][WIDTH-1] ^ st_b[STAGES-1][WIDTH-1]
                   ^ nxt_res[STAGES-1][WIDTH-1];

    // Flags are registered alongside the final sum with the same enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else if (adv) begin
            zero <= (nxt_res[STAGES-1] == '0);
            neg  <= nxt_res[STAGES-1][WIDTH-1];
            ovf  <= msb_cin ^ ch_co[STAGES-1];
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases plus random
// traffic compared against a latency-queue reference model.
module tb_pipelined_adder;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic [W-1:0] sum;
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic         zero;
    logic         neg;
    logic         ovf;
    logic [2:0]   mf [S];
`endif

    int checks = 0;
    int errors = 0;

    // Reference: expected {valid, cout:sum} for each of the S cycles of latency.
    logic         mv [S];
    logic [W:0]   mr [S];

    pipelined_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_ADDER_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [W:0] obs, input logic [W:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < S; k++) begin
            mv[k] = 1'b0;
            mr[k] = '0;
`ifdef PIPELINED_ADDER_FLAGS_EN
            mf[k] = '0;
`endif
        end
    endtask

    // One clock cycle: check outputs, drive inputs, check in_ready, update model.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic icin, input logic ordy);
        logic         adv;
        logic [W-1:0] bp;
        logic [W:0]   r;
        @(negedge clk);
        chk_bit("out_valid", out_valid, mv[S-1]);
        if (mv[S-1]) begin
            chk_vec("cout_sum", {cout, sum}, mr[S-1]);
`ifdef PIPELINED_ADDER_FLAGS_EN
            chk_vec("flags", {{(W-2){1'b0}}, zero, neg, ovf}, {{(W-2){1'b0}}, mf[S-1]});
`endif
        end
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        cin       = icin;
        out_ready = ordy;
        #1;
        adv = !(mv[S-1] && !ordy);
        chk_bit("in_ready", in_ready, adv);
        bp = isub ? ~ib : ib;
        r  = {1'b0, ia} + {1'b0, bp} + {{W{1'b0}}, (isub ? 1'b1 : icin)};
        @(posedge clk);
        if (adv) begin
            for (int k = S - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                mr[k] = mr[k-1];
`ifdef PIPELINED_ADDER_FLAGS_EN
                mf[k] = mf[k-1];
`endif
            end
            mv[0] = iv;
            mr[0] = r;
`ifdef PIPELINED_ADDER_FLAGS_EN
            mf[0] = {(r[W-1:0] == '0), r[W-1],
                     (ia[W-1] == bp[W-1]) && (r[W-1] != ia[W-1])};
`endif
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, W'($urandom), W'($urandom), 1'b0, 1'b0, ordy);
    endtask

    initial begin
        clear_model();

        // Reset state while held in reset, then release away from an edge.
        #3;
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_vec("rst_cout_sum", {cout, sum}, '0);
        #9 rst_n = 1'b1;
        idle(1'b1);

        // Directed arithmetic cases.
        step(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'd5,         32'd7,         1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h8000_0000, 32'd1,         1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < S + 1; i++) idle(1'b1);

        // Back-to-back stream of 8 operations.
        for (int i = 0; i < 8; i++)
            step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < S + 1; i++) idle(1'b1);

        // Fill the pipe, stall the output for 3 cycles, then drain.
        for (int i = 0; i < S; i++)
            step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < S + 1; i++) idle(1'b1);

        // Reset with two operations in flight, one already at the output.
        step(1'b1, 32'h0000_1234, 32'h0000_0099, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("async_rst_out_valid", out_valid, 1'b0);
        chk_vec("async_rst_cout_sum", {cout, sum}, '0);
        clear_model();
        #1 rst_n = 1'b1;
        for (int i = 0; i < S + 2; i++) idle(1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 9) == 0) ra = '1;
            if ($urandom_range(0, 9) == 0) rb = '0;
            step(($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < S + 2; i++) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the 1-bit full adder.
- Computes WIDTH-bit A+B or A-B in STAGES carry-chained chunks, one chunk per pipeline stage, with the carry registered between stages.
- Used in the EX stage and address-generation paths where a full-width ripple chain cannot close timing.
- Valid/ready handshake on both sides; accepts one operation per cycle when not stalled.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, pipeline stages; WIDTH mod STAGES must be 0. CW = WIDTH/STAGES is the chunk width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  adder can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1: A-B (B inverted, carry-in forced 1); 0: A+B+cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, mod 2^WIDTH.
- cout  out  1  carry-out of MSB; for sub, 1 means no borrow (A>=B unsigned).

Behaviour:
- Reset (rst_n low, async): all stage valid bits, carries, partial sums and skewed operands are cleared; out_valid=0, sum=0, cout=0. in_ready=1 in the first cycle after reset release.
- Global advance enable: adv = ~(v[STAGES-1] & ~out_ready). in_ready = adv. The pipeline holds all state while adv=0.
- Transfers occur when in_valid & in_ready. With adv=1, stage 0 loads v[0] = in_valid & in_ready. Bubbles (v=0) propagate normally, with no compaction.
- Stage k (0..STAGES-1) adds chunk k of A and chunk k of B' (B' = sub ? ~b : b), plus the carry from stage k-1. Stage 0 carry-in = sub ? 1 : cin. Each stage produces CW sum bits and a registered carry.
- Skew: chunks above k are carried forward in delay registers. Lower result chunks are carried forward so all WIDTH bits are aligned at the last stage.
- Latency: exactly STAGES cycles from input handshake to out_valid, when there is no backpressure. Throughput is 1 per cycle.
- Outputs sum, cout and out_valid come straight from the last-stage registers. sum and cout are stable while out_valid & ~out_ready.
- Stage 0 registers only when adv=1; data on a/b is ignored when in_valid=0.
- Simultaneous events:
  - Output pop and input push in the same cycle are both accepted; the pipeline stays full.
  - out_ready=0 with a full pipeline gives in_ready=0 combinationally.
- STAGES=1 degenerates to a registered full-width adder with 1-cycle latency.
- Reset mid-operation: all in-flight results are discarded and no out_valid is asserted afterwards for them.
- Overflow wraps modulo 2^WIDTH; cout reports it.

Optional Feature:
- Macro PIPELINED_ADDER_FLAGS_EN.
- When defined, adds three output ports, each 1 bit and registered alongside sum (reset 0):
  - zero: sum==0.
  - neg: sum[WIDTH-1].
  - ovf: signed overflow = carry into MSB XOR cout.
- These flags serve branch compare (BEQ/BLT/BLTU via sub=1).
- When undefined, the ports and their logic are absent.

Decomposition:
- Shared package adder_pkg:
  - localparam defaults ADD_WIDTH=32, ADD_STAGES=4.
  - Function for chunk index bounds.
  - Typedef for the opcode bit (ADD/SUB encoding).
- One natural sub-module: adder_chunk_stage. It takes CW-bit a/b chunks and carry-in, and produces CW-bit sum and carry-out. Its arithmetic is purely combinational, built from the 1-bit adder cell chain. The top level instantiates it STAGES times with the pipeline registers.

Test Plan:
- Add, defaults: a=0x0000_FFFF, b=0x0000_0001, sub=0, cin=0 -> exactly 4 cycles later out_valid=1, sum=0x0001_0000, cout=0. The carry must cross the chunk boundary.
- Full-carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1. With flags enabled: zero=1, ovf=0.
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0. With flags: neg=1. Then a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1.
- Back-to-back stream: 8 consecutive ops with out_ready=1 -> 8 results in order on consecutive cycles, starting at cycle 4.
- Backpressure: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, and sum/cout/out_valid are held stable. Releasing out_ready drains in order with no loss or duplication.
- Reset mid-flight: 2 ops in flight, pulse rst_n low asynchronously between clock edges -> out_valid=0 and sum=0 immediately, and neither op emerges afterwards.
